// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default oversample ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic          tick_reg;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else if (div_cnt_reg == CW'(DIV - 1)) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
      tick_reg    <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 receiver front end: synchronises uart_rx, oversamples at mid-bit and strobes each byte.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  logic          tick;
  logic [1:0]    sync_reg;
  logic          rx_s;
  uart_state_t   state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          rx_valid_reg, rx_valid_next;
  logic          frame_err_reg, frame_err_next;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .sys_clk(sys_clk),
    .reset  (reset),
    .tick   (tick)
  );

  assign rx_s = sync_reg[1];

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sync_reg      <= 2'b11;
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], uart_rx};
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // All state decisions happen only on oversample ticks; strobes are registered
  // so they appear the cycle after the deciding tick.
  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end
        START: begin
          if (tick_cnt_reg == HALF_M1) begin
            tick_cnt_next = '0;
            if (!rx_s) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt_reg == FULL_M1) begin
            tick_cnt_next = '0;
            shreg_next    = {rx_s, shreg_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 3'd1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt_reg == FULL_M1) begin
            tick_cnt_next = '0;
            if (rx_s) begin
              rx_data_next  = shreg_reg;
              rx_valid_next = 1'b1;
              state_next    = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = BREAK;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_next    = IDLE;
            tick_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE;
          tick_cnt_next = '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg == DATA) || (state_reg == STOP) || (state_reg == BREAK);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: serial frames in, strobed bytes compared to a frame-level model.
module tb_uart_rx_frontend;

  localparam int BIT_CLKS = 160;

  logic       sys_clk;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int vec_cnt;
  int miscompares;

  // Frame-level reference model
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  int         exp_ferr;

  // Observations from the monitor
  logic [7:0] got_q[$];
  int         ferr_cnt;
  int         both_cnt;
  int         long_cnt;
  int         bad_busy;
  bit         busy_seen;
  logic       valid_d;
  logic       ferr_d;
  logic       busy_d;

  uart_rx_frontend #(
    .CLK_HZ    (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if ((rx_valid && valid_d) || (frame_err && ferr_d)) long_cnt++;
    if (rx_valid && (rx_busy || !busy_d)) bad_busy++;
    if (rx_busy) busy_seen = 1'b1;
    valid_d = rx_valid;
    ferr_d  = frame_err;
    busy_d  = rx_busy;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    ferr_cnt  = 0;
    exp_ferr  = 0;
    busy_seen = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back(d);
      exp_data = d;
    end else begin
      exp_ferr++;
    end
  endtask

  // Leaves the line at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bclk);
    uart_rx = 1'b0;
    hold(bclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      hold(bclk);
    end
    uart_rx = stop_ok;
    hold(bclk);
    model_frame(d, stop_ok);
  endtask

  task automatic check_stream(input string name);
    vec_cnt++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d strobes, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vec_cnt++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, got_q[i], exp_q[i]);
      end
    end
    vec_cnt++;
    if (ferr_cnt !== exp_ferr) begin
      miscompares++;
      $display("FAIL %s_frame_err: got %0d pulses, expected %0d", name, ferr_cnt, exp_ferr);
    end
    vec_cnt++;
    if (rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL %s_rx_data: got %02h, expected %02h", name, rx_data, exp_data);
    end
  endtask

  task automatic test_reset();
    uart_rx = 1'b1;
    reset   = 1'b0;
    hold(5);
    vec_cnt++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    reset = 1'b1;
    hold(2 * BIT_CLKS);
  endtask

  task automatic test_single();
    clear_obs();
    send_frame(8'h55, 1'b1, BIT_CLKS);
    hold(2 * BIT_CLKS);
    check_stream("single");
    vec_cnt++;
    if (busy_seen !== 1'b1 || bad_busy !== 0) begin
      miscompares++;
      $display("FAIL single_busy: got seen=%b bad=%0d, expected seen=1 bad=0", busy_seen, bad_busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'hA3, 1'b1, BIT_CLKS);
    send_frame(8'h0F, 1'b1, BIT_CLKS);
    hold(2 * BIT_CLKS);
    check_stream("b2b");
  endtask

  task automatic test_glitch();
    clear_obs();
    uart_rx = 1'b0;
    hold(40);
    uart_rx = 1'b1;
    hold(3 * BIT_CLKS);
    check_stream("glitch");
    vec_cnt++;
    if (busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy: got busy_seen=%b, expected 0", busy_seen);
    end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'hC6, 1'b0, BIT_CLKS);
    hold(3 * BIT_CLKS);
    uart_rx = 1'b1;
    hold(2 * BIT_CLKS);
    check_stream("ferr");
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    hold(2 * BIT_CLKS);
    check_stream("ferr_next");
  endtask

  task automatic test_midframe_reset();
    logic [7:0] d;
    d = 8'h99;
    clear_obs();
    uart_rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      uart_rx = d[i];
      hold(BIT_CLKS);
    end
    uart_rx = d[4];
    hold(BIT_CLKS / 2);
    vec_cnt++;
    if (rx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: got rx_busy=%b, expected 1", rx_busy);
    end
    reset = 1'b0;
    hold(2);
    vec_cnt++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got data=%02h v=%b fe=%b busy=%b, expected all 0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    reset    = 1'b1;
    uart_rx  = 1'b1;
    exp_data = 8'h00;
    hold(2 * BIT_CLKS);
    check_stream("mid_abandon");
    send_frame(8'h81, 1'b1, BIT_CLKS);
    hold(2 * BIT_CLKS);
    check_stream("mid_next");
  endtask

  task automatic test_skew();
    clear_obs();
    send_frame(8'h00, 1'b1, 155);
    hold(2 * BIT_CLKS);
    send_frame(8'hFF, 1'b1, 165);
    hold(2 * BIT_CLKS);
    send_frame(8'h00, 1'b1, 165);
    hold(2 * BIT_CLKS);
    send_frame(8'hFF, 1'b1, 155);
    hold(2 * BIT_CLKS);
    check_stream("skew");
  endtask

  task automatic test_random();
    clear_obs();
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(155, 165)));
      hold(int'($urandom_range(0, 300)));
    end
    hold(2 * BIT_CLKS);
    check_stream("random");
  endtask

  task automatic test_invariants();
    vec_cnt++;
    if (both_cnt !== 0 || long_cnt !== 0) begin
      miscompares++;
      $display("FAIL strobe_shape: got both=%0d long=%0d, expected 0 and 0", both_cnt, long_cnt);
    end
    vec_cnt++;
    if (bad_busy !== 0) begin
      miscompares++;
      $display("FAIL busy_at_strobe: got %0d bad strobes, expected 0", bad_busy);
    end
  endtask

  initial begin
    vec_cnt     = 0;
    miscompares = 0;
    exp_data    = 8'h00;
    exp_ferr    = 0;
    ferr_cnt    = 0;
    both_cnt    = 0;
    long_cnt    = 0;
    bad_busy    = 0;
    busy_seen   = 1'b0;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    busy_d      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_midframe_reset();
    test_skew();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
